mdu_issue_ctrl: RTL and testbench

MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

---
 rtl/mdu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_mdu_issue_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue control between the E stage and a multi-cycle multiply/divide unit.
// Produces the start pulse, stalls D while the unit is engaged and flags Busy protocol errors.
module mdu_issue_ctrl #(
    parameter int MU_CYCLE    = 5,
    parameter int D_CYCLE     = 10,
    parameter int ACK_TIMEOUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic        e_hold,
    input  logic [3:0]  e_op,
    input  logic        d_md,
    input  logic        int_req,
    input  logic        mdu_busy,
    output logic        mdu_start,
    output logic [3:0]  mdu_op,
    output logic        stall_d,
    output logic [1:0]  rd_sel,
    output logic        proto_err,
    output logic [15:0] stall_cnt
);

    localparam int MAXC = (MU_CYCLE > D_CYCLE) ? MU_CYCLE : D_CYCLE;
    localparam int CW   = $clog2(MAXC + 2);
    localparam int TW   = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RUN} state_t;

    state_t        state, state_n;
    logic          issued;
    logic          go;
    logic          op_arith, op_mul, op_mdu;
    logic [TW-1:0] to_cnt;
    logic [CW-1:0] run_cnt, len_q;
    logic          err_set, to_inc, run_set1, run_inc;

    // A held instruction may only issue once; int_req kills the issue outright.
    assign go       = e_valid & ~int_req & (~e_hold | ~issued);
    assign op_arith = (e_op >= 4'd1) && (e_op <= 4'd4);
    assign op_mul   = (e_op == 4'd1) || (e_op == 4'd2);
    assign op_mdu   = (e_op >= 4'd1) && (e_op <= 4'd6);

    assign mdu_start = ~reset & go & op_arith & (state == IDLE);
    assign mdu_op    = (~reset & go & op_mdu) ? e_op : 4'd0;
    assign stall_d   = d_md & (mdu_start | mdu_busy | (state != IDLE));

    always_comb begin
        rd_sel = 2'd0;
        if (e_valid && e_op == 4'd7) rd_sel = 2'd1;
        else if (e_valid && e_op == 4'd8) rd_sel = 2'd2;
    end

    always_comb begin
        state_n  = state;
        err_set  = 1'b0;
        to_inc   = 1'b0;
        run_set1 = 1'b0;
        run_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (mdu_start) state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (mdu_busy) begin
                    state_n  = RUN;
                    run_set1 = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            RUN: begin
                if (mdu_busy) begin
                    run_inc = 1'b1;
                end else begin
                    state_n = IDLE;
                    err_set = (run_cnt != len_q);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            issued    <= 1'b0;
            proto_err <= 1'b0;
            stall_cnt <= 16'd0;
            to_cnt    <= '0;
            run_cnt   <= '0;
            len_q     <= '0;
        end else begin
            state <= state_n;
            if (go) issued <= 1'b1;
            else if (!e_hold) issued <= 1'b0;
            if (stall_d && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (err_set) proto_err <= 1'b1;
            if (mdu_start) begin
                len_q   <= op_mul ? CW'(MU_CYCLE) : CW'(D_CYCLE);
                to_cnt  <= '0;
                run_cnt <= '0;
            end else begin
                if (to_inc) to_cnt <= to_cnt + TW'(1);
                // Saturate so an overlong Busy cannot wrap back to the expected length.
                if (run_set1) run_cnt <= CW'(1);
                else if (run_inc && run_cnt != '1) run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed scenarios followed by random traffic,
// with a behavioural MDU and a transaction-level reference model.
module tb_mdu_issue_ctrl;

    localparam int MU = 5;
    localparam int DV = 10;
    localparam int TO = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        e_valid = 1'b0, e_hold = 1'b0, d_md = 1'b0, int_req = 1'b0, mdu_busy = 1'b0;
    logic [3:0]  e_op = 4'd0;
    logic        mdu_start, stall_d, proto_err;
    logic [3:0]  mdu_op;
    logic [1:0]  rd_sel;
    logic [15:0] stall_cnt;

    mdu_issue_ctrl #(.MU_CYCLE(MU), .D_CYCLE(DV), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_hold(e_hold), .e_op(e_op),
        .d_md(d_md), .int_req(int_req), .mdu_busy(mdu_busy), .mdu_start(mdu_start),
        .mdu_op(mdu_op), .stall_d(stall_d), .rd_sel(rd_sel), .proto_err(proto_err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        st;
        logic [3:0]  op;
        logic        sd;
        logic [1:0]  rd;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_start = 0;
    bit   push_en = 1'b0;

    // Reference model: one open transaction at most, described by what has been seen of it.
    bit          m_issued = 0, m_open = 0, m_acked = 0, m_err = 0;
    int          m_exp = 0, m_wait = 0, m_runlen = 0;
    logic [15:0] m_scnt = 16'd0;
    int          mdu_rem = 0;
    int          mode_len = MU;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mdu_start) n_start++;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("mdu_start", 32'(mdu_start), 32'(e.st));
            chk("mdu_op",    32'(mdu_op),    32'(e.op));
            chk("stall_d",   32'(stall_d),   32'(e.sd));
            chk("rd_sel",    32'(rd_sel),    32'(e.rd));
            chk("proto_err", 32'(proto_err), 32'(e.err));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
        end
    end

    // One clock of stimulus: apply inputs, predict outputs, then advance model and MDU at the edge.
    task automatic cyc(input logic ev, input logic eh, input logic [3:0] op,
                       input logic dm, input logic ir, input logic rs);
        logic go, st, sd;
        logic [3:0] opx;
        logic [1:0] rd;
        exp_t e;
        e_valid = ev; e_hold = eh; e_op = op; d_md = dm; int_req = ir; reset = rs;
        mdu_busy = (mdu_rem != 0);
        go  = ev && !ir && (!eh || !m_issued);
        st  = !rs && go && op >= 4'd1 && op <= 4'd4 && !m_open;
        opx = (!rs && go && op >= 4'd1 && op <= 4'd6) ? op : 4'd0;
        rd  = !ev ? 2'd0 : (op == 4'd7) ? 2'd1 : (op == 4'd8) ? 2'd2 : 2'd0;
        sd  = dm && (st || mdu_busy || m_open);
        e.st = st; e.op = opx; e.sd = sd; e.rd = rd; e.err = m_err; e.cnt = m_scnt;
        if (push_en) q.push_back(e);
        @(posedge clk);
        if (rs) begin
            m_issued = 0; m_open = 0; m_acked = 0; m_err = 0;
            m_wait = 0; m_runlen = 0; m_scnt = 16'd0;
        end else begin
            if (go) m_issued = 1;
            else if (!eh) m_issued = 0;
            if (sd && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            if (st) begin
                m_open = 1; m_acked = 0; m_wait = 0; m_runlen = 0;
                m_exp = (op <= 4'd2) ? MU : DV;
            end else if (m_open && !m_acked) begin
                if (mdu_busy) begin
                    m_acked = 1; m_runlen = 1;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin m_err = 1; m_open = 0; end
                end
            end else if (m_open) begin
                if (mdu_busy) m_runlen++;
                else begin
                    m_open = 0;
                    if (m_runlen != m_exp) m_err = 1;
                end
            end
        end
        if (st) mdu_rem = mode_len;
        else if (mdu_rem != 0) mdu_rem--;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int s;
        logic ev, eh, dm, ir, rs;
        logic [3:0] op;
        int r;

        cyc(0, 0, 4'd0, 0, 0, 1);
        cyc(0, 0, 4'd0, 0, 0, 1);
        push_en = 1'b1;
        chk("rst_err", 32'(proto_err), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);

        // mult, D-stage MD op arriving the next cycle, well-behaved MDU
        s = n_start; mode_len = MU;
        cyc(1, 0, 4'd2, 0, 0, 0);
        repeat (7) cyc(0, 0, 4'd0, 1, 0, 0);
        chk("mult_starts", 32'(n_start - s), 32'd1);
        chk("mult_stalls", 32'(stall_cnt), 32'd6);
        chk("mult_err", 32'(proto_err), 32'd0);

        // divu held for three cycles issues once
        s = n_start; mode_len = DV;
        cyc(1, 0, 4'd3, 0, 0, 0);
        repeat (3) cyc(1, 1, 4'd3, 0, 0, 0);
        idle(9);
        cyc(0, 0, 4'd0, 1, 0, 0);
        chk("divu_starts", 32'(n_start - s), 32'd1);
        chk("divu_err", 32'(proto_err), 32'd0);

        // div coinciding with int_req is dropped; following mfhi is not stalled
        s = n_start;
        cyc(1, 0, 4'd4, 0, 1, 0);
        cyc(1, 0, 4'd7, 1, 0, 0);
        chk("int_starts", 32'(n_start - s), 32'd0);
        idle(2);

        // mult then mthi waiting in D until Busy falls
        mode_len = MU;
        cyc(1, 0, 4'd2, 1, 0, 0);
        repeat (7) cyc(0, 0, 4'd0, 1, 0, 0);
        cyc(1, 0, 4'd5, 0, 0, 0);
        idle(2);
        chk("mthi_err", 32'(proto_err), 32'd0);

        // short Busy is a protocol error and sticks
        mode_len = 4;
        cyc(1, 0, 4'd2, 0, 0, 0);
        idle(8);
        chk("short_err", 32'(proto_err), 32'd1);
        idle(3);
        chk("short_sticky", 32'(proto_err), 32'd1);

        // MDU never answers: error after ACK_TIMEOUT cycles of waiting
        cyc(0, 0, 4'd0, 0, 0, 1);
        chk("clr_err", 32'(proto_err), 32'd0);
        mode_len = 0;
        cyc(1, 0, 4'd2, 0, 0, 0);
        idle(1);
        chk("noack_early", 32'(proto_err), 32'd0);
        idle(1);
        chk("noack_err", 32'(proto_err), 32'd1);

        // reset in the third RUN cycle; residual Busy only stalls while present
        cyc(0, 0, 4'd0, 0, 0, 1);
        mode_len = MU;
        cyc(1, 0, 4'd2, 0, 0, 0);
        idle(2);
        cyc(0, 0, 4'd0, 0, 0, 1);
        chk("midrun_cnt", 32'(stall_cnt), 32'd0);
        repeat (4) cyc(0, 0, 4'd8, 1, 0, 0);
        idle(4);

        repeat (3000) begin
            ev = ($urandom_range(0, 3) != 0);
            eh = ($urandom_range(0, 2) == 0);
            op = 4'($urandom_range(0, 8));
            dm = 1'($urandom_range(0, 1));
            ir = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 99) == 0);
            r  = $urandom_range(0, 9);
            mode_len = (op <= 4'd2) ? MU : DV;
            if (r == 7) mode_len = mode_len - 1;
            else if (r == 8) mode_len = mode_len + 1;
            else if (r == 9) mode_len = 0;
            cyc(ev, eh, op, dm, ir, rs);
        end

        push_en = 1'b0;
        idle(2);
        chk("drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
